immgen: RTL and testbench

- RV32I immediate generator in the decode stage.
- Extracts and sign-extends the immediate field from a 32-bit instruction based on its opcode.
- Reports the decoded immediate format and flags unrecognised opcodes.
- Primary output o_imm is purely combinational. A registered copy, with format and flag, is provided for pipelined consumers.

---
 rtl/immgen.sv | 111 +++++++++++
 tb/tb_immgen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/immgen.sv
// RV32I immediate generator: decodes the opcode, sign-extends the immediate
// combinationally, and keeps an enabled, registered copy for pipelined users.
module immgen #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_imm_q,
    output logic [2:0]      o_fmt_q,
    output logic            o_illegal_q
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    fmt_e            fmt;
    logic            illegal;
    logic [XLEN-1:0] imm;

    logic [XLEN-1:0] imm_d, imm_q;
    logic [2:0]      fmt_d, fmt_q;
    logic            illegal_d, illegal_q;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        unique case (i_instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_FENCE, OPC_SYSTEM:  fmt = FMT_I;
            OPC_STORE:              fmt = FMT_S;
            OPC_BRANCH:             fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:     fmt = FMT_U;
            OPC_JAL:                fmt = FMT_J;
            OPC_OP:                 fmt = FMT_NONE;
            default:                illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I:   imm = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   imm = {i_instr[31:12], 12'b0};
            FMT_J:   imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign o_imm     = imm;
    assign o_fmt     = fmt;
    assign o_illegal = illegal;

    always_comb begin
        imm_d     = imm_q;
        fmt_d     = fmt_q;
        illegal_d = illegal_q;
        if (i_en) begin
            imm_d     = imm;
            fmt_d     = fmt;
            illegal_d = illegal;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous and wins over the enable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            imm_q     <= '0;
            fmt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            imm_q     <= imm_d;
            fmt_q     <= fmt_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_imm_q     = imm_q;
    assign o_fmt_q     = fmt_q;
    assign o_illegal_q = illegal_q;

endmodule

// File: tb/tb_immgen.sv
// Self-checking bench for immgen: directed vectors, a golden word sweep,
// randomized comparison against an arithmetic reference model, and the register path.
module tb_immgen;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic [31:0] i_instr;
    logic [31:0] o_imm;
    logic [2:0]  o_fmt;
    logic        o_illegal;
    logic [31:0] o_imm_q;
    logic [2:0]  o_fmt_q;
    logic        o_illegal_q;

    int checks = 0;
    int errors = 0;

    immgen #(.XLEN(32)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_instr     (i_instr),
        .o_imm       (o_imm),
        .o_fmt       (o_fmt),
        .o_illegal   (o_illegal),
        .o_imm_q     (o_imm_q),
        .o_fmt_q     (o_fmt_q),
        .o_illegal_q (o_illegal_q)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: the immediate is rebuilt as a signed integer from its
    // scattered fields with weights, then wrapped to 32 bits.
    function automatic void model(input logic [31:0] ins, output logic [31:0] imm,
                                  output logic [2:0] fmt, output logic ill);
        longint v;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
                fmt = 3'd1;
                v = longint'(ins[31:20]);
                if (ins[31]) v = v - 4096;
            end
            7'h23: begin
                fmt = 3'd2;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v = v - 4096;
            end
            7'h63: begin
                fmt = 3'd3;
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                  + longint'(ins[11:8]) * 2;
                if (ins[31]) v = v - 4096;
            end
            7'h37, 7'h17: begin
                fmt = 3'd4;
                v = longint'(ins[31:12]) * 4096;
            end
            7'h6F: begin
                fmt = 3'd5;
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                  + longint'(ins[30:21]) * 2;
                if (ins[31]) v = v - 1048576;
            end
            7'h33: fmt = 3'd0;
            default: ill = 1'b1;
        endcase
        imm = 32'(v);
    endfunction

    task automatic test_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_instr = 32'hFFF00093;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        checks++;
        if (o_imm_q !== 32'h0 || o_fmt_q !== 3'd0 || o_illegal_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_q: got imm_q=%h fmt_q=%0d ill_q=%b, want 0/0/0",
                     o_imm_q, o_fmt_q, o_illegal_q);
        end
        checks++;
        if (o_imm !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL reset_comb_tracks: got %h want ffffffff", o_imm);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ins [7]  = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123452B7,
                                  32'h001000EF, 32'h002081B3, 32'h0000007F};
        logic [31:0] imm [7]  = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000,
                                  32'h00000800, 32'h00000000, 32'h00000000};
        logic [2:0]  fmt [7]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
        logic        ill [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            i_instr = ins[k];
            #1;
            checks++;
            if (o_imm !== imm[k] || o_fmt !== fmt[k] || o_illegal !== ill[k]) begin
                errors++;
                $display("FAIL directed[%0d] %h: got imm=%h fmt=%0d ill=%b want %h/%0d/%b",
                         k, ins[k], o_imm, o_fmt, o_illegal, imm[k], fmt[k], ill[k]);
            end
        end
    endtask

    task automatic test_golden_sweep();
        logic [31:0] ins [16] = '{32'h80000003, 32'h7FF00013, 32'hFFF00067, 32'h0FF0000F,
                                  32'h80000073, 32'h40505293, 32'hFE000FA3, 32'h02000023,
                                  32'h80000063, 32'h00000FE3, 32'hFFFFF0B7, 32'h00001017,
                                  32'h800000EF, 32'h7FFFF06F, 32'hFFFFFFB3, 32'hFFFFFFFF};
        logic [31:0] gold [16] = '{32'hFFFFF800, 32'h000007FF, 32'hFFFFFFFF, 32'h000000FF,
                                   32'hFFFFF800, 32'h00000405, 32'hFFFFFFFF, 32'h00000020,
                                   32'hFFFFF000, 32'h0000081E, 32'hFFFFF000, 32'h00001000,
                                   32'hFFF00000, 32'h000FFFFE, 32'h00000000, 32'h00000000};
        int mism = 0;
        for (int k = 0; k < 16; k++) begin
            i_instr = ins[k];
            #1;
            if (o_imm !== gold[k]) begin
                mism++;
                $display("FAIL golden[%0d] %h: got %h want %h", k, ins[k], o_imm, gold[k]);
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL golden_sweep: got %0d mismatches want 0", mism);
        end
    endtask

    task automatic test_random_comb();
        logic [6:0]  opcs [12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                                   7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
        logic [31:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        logic [31:0] r;
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            if (k % 4 != 3) r[6:0] = opcs[$urandom_range(0, 11)];
            i_instr = r;
            #1;
            model(r, e_imm, e_fmt, e_ill);
            checks++;
            if (o_imm !== e_imm || o_fmt !== e_fmt || o_illegal !== e_ill) begin
                errors++;
                $display("FAIL random_comb %h: got imm=%h fmt=%0d ill=%b want %h/%0d/%b",
                         r, o_imm, o_fmt, o_illegal, e_imm, e_fmt, e_ill);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_en    = 1'b1;
        i_instr = 32'hFFF00093;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_imm_q !== 32'hFFFFFFFF || o_fmt_q !== 3'd1 || o_illegal_q !== 1'b0) begin
            errors++;
            $display("FAIL reg_capture: got %h/%0d/%b want ffffffff/1/0",
                     o_imm_q, o_fmt_q, o_illegal_q);
        end
        @(negedge i_clk);
        i_en    = 1'b0;
        i_instr = 32'h0000007F;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_imm_q !== 32'hFFFFFFFF || o_fmt_q !== 3'd1 || o_illegal_q !== 1'b0) begin
            errors++;
            $display("FAIL reg_hold: got %h/%0d/%b want ffffffff/1/0",
                     o_imm_q, o_fmt_q, o_illegal_q);
        end
        @(negedge i_clk);
        i_en = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_imm_q !== 32'h0 || o_fmt_q !== 3'd0 || o_illegal_q !== 1'b1) begin
            errors++;
            $display("FAIL reg_illegal: got %h/%0d/%b want 0/0/1",
                     o_imm_q, o_fmt_q, o_illegal_q);
        end
        @(negedge i_clk);
        i_instr = 32'h123452B7;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_imm_q !== 32'h0 || o_fmt_q !== 3'd0 || o_illegal_q !== 1'b0
            || o_imm !== 32'h12345000) begin
            errors++;
            $display("FAIL reg_midreset: got q=%h/%0d/%b comb=%h want 0/0/0 comb=12345000",
                     o_imm_q, o_fmt_q, o_illegal_q, o_imm);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q_imm, c_imm;
        logic [2:0]  q_fmt, c_fmt;
        logic        q_ill, c_ill;
        logic [31:0] r;
        logic        en, rst;
        q_imm = '0; q_fmt = '0; q_ill = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge i_clk);
            r   = $urandom;
            en  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 19) != 0);
            i_instr = r;
            i_en    = en;
            i_rst_n = rst;
            model(r, c_imm, c_fmt, c_ill);
            if (!rst) begin
                q_imm = '0; q_fmt = '0; q_ill = 1'b0;
            end else if (en) begin
                q_imm = c_imm; q_fmt = c_fmt; q_ill = c_ill;
            end
            @(posedge i_clk);
            #1;
            checks++;
            if (o_imm_q !== q_imm || o_fmt_q !== q_fmt || o_illegal_q !== q_ill) begin
                errors++;
                $display("FAIL back_to_back[%0d] en=%b rst_n=%b: got %h/%0d/%b want %h/%0d/%b",
                         k, en, rst, o_imm_q, o_fmt_q, o_illegal_q, q_imm, q_fmt, q_ill);
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        i_instr = '0;
        test_reset();
        test_directed();
        test_golden_sweep();
        test_random_comb();
        test_registered();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
